// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an upstream 4:1 mux through the enabled channels,
// waits DWELL cycles on each one, samples y_in into a shadow word, and
// presents the finished word on a valid/ready output. Continuous mode
// starts the next scan on the cycle after a word is accepted.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] mask,
  input  logic       y_in,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Dwell count at which the current channel is sampled.
  localparam logic [3:0] LP_CNT_LAST = 4'(DWELL - 1);

  // Registered state and outputs
  state_t     r_state;
  logic [1:0] r_sel;
  logic [3:0] r_data;
  logic       r_valid;
  logic       r_busy;
  logic [3:0] r_mask;
  logic [3:0] r_shadow;
  logic [3:0] r_cnt;

  // Next-state values
  state_t     w_state_next;
  logic [1:0] w_sel_next;
  logic [3:0] w_data_next;
  logic       w_valid_next;
  logic       w_busy_next;
  logic [3:0] w_mask_next;
  logic [3:0] w_shadow_next;
  logic [3:0] w_cnt_next;

  // Channel search helpers
  logic [1:0] w_first_ch;      // lowest enabled channel of the live mask input
  logic       w_mask_any;      // live mask input has at least one channel
  logic [3:0] w_above;         // latched-enabled channels above the current sel
  logic [1:0] w_next_ch;       // lowest of w_above
  logic       w_next_ch_en;    // a higher enabled channel exists
  logic [3:0] w_shadow_sampled;
  logic       w_accept;

  assign w_mask_any = |mask;
  assign w_accept   = r_valid & ready;

  // Per-channel flag: enabled in the latched mask and strictly above sel.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_above
      assign w_above[gi] = r_mask[gi] & (r_sel < 2'(gi));
    end
  endgenerate

  // Priority-encode the lowest enabled channel of the live mask input.
  always_comb begin
    w_first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        w_first_ch = 2'(i);
      end
    end
  end

  // Priority-encode the next enabled channel above the current one.
  always_comb begin
    w_next_ch    = 2'd0;
    w_next_ch_en = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (w_above[i]) begin
        w_next_ch    = 2'(i);
        w_next_ch_en = 1'b1;
      end
    end
  end

  // Shadow word with the current mux output written into bit sel.
  always_comb begin
    w_shadow_sampled        = r_shadow;
    w_shadow_sampled[r_sel] = y_in;
  end

  // Next-state and output logic for the scan FSM.
  always_comb begin
    w_state_next  = r_state;
    w_sel_next    = r_sel;
    w_data_next   = r_data;
    w_valid_next  = r_valid;
    w_mask_next   = r_mask;
    w_shadow_next = r_shadow;
    w_cnt_next    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        w_sel_next = 2'd0;
        // An empty mask has nothing to scan, so the request is dropped.
        if (start && w_mask_any) begin
          w_mask_next   = mask;
          w_shadow_next = 4'd0;
          w_sel_next    = w_first_ch;
          w_cnt_next    = 4'd0;
          w_state_next  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_shadow_next = w_shadow_sampled;
          w_cnt_next    = 4'd0;
          if (w_next_ch_en) begin
            w_sel_next = w_next_ch;
          end else begin
            // Disabled channels were never written, the AND only guards
            // against a stale shadow bit ever leaking out.
            w_data_next  = w_shadow_sampled & r_mask;
            w_valid_next = 1'b1;
            w_state_next = ST_HOLD;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end

      ST_HOLD: begin
        if (w_accept) begin
          w_valid_next = 1'b0;
          if (cont && w_mask_any) begin
            // Back-to-back scan: relatch the mask with no idle bubble.
            w_mask_next   = mask;
            w_shadow_next = 4'd0;
            w_sel_next    = w_first_ch;
            w_cnt_next    = 4'd0;
            w_state_next  = ST_SETTLE;
          end else begin
            w_sel_next   = 2'd0;
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_sel_next   = 2'd0;
        w_valid_next = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= 2'd0;
      r_data   <= 4'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_mask   <= 4'd0;
      r_shadow <= 4'd0;
      r_cnt    <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel_next;
      r_data   <= w_data_next;
      r_valid  <= w_valid_next;
      r_busy   <= w_busy_next;
      r_mask   <= w_mask_next;
      r_shadow <= w_shadow_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign sel   = r_sel;
  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: table vectors, directed multi-cycle
// sequences and randomized scans against a channel-list reference model.
module tb_mux_scan_ctrl;

  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] mask;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic [3:0] mux_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Upstream 4:1 mux
  assign y_in = mux_in[sel];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cont  (cont),
    .mask  (mask),
    .y_in  (y_in),
    .sel   (sel),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy)
  );

  typedef struct {
    logic [3:0] in_w;
    logic [3:0] m;
    logic [3:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m[i]);
    return n;
  endfunction

  // n-th enabled channel in ascending order
  function automatic logic [1:0] nth_ch(input logic [3:0] m, input int n);
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (seen == n) return 2'(i);
        seen++;
      end
    end
    return 2'd0;
  endfunction

  // Called just after the edge that began a scan of mask m. Counts cycles
  // until valid, checking sel visits the enabled channels DWELL cycles each.
  task automatic wait_valid(input logic [3:0] m, input bit scramble,
                            output int lat, output bit trace_ok);
    int k_d = popcount(m) * DWELL;
    lat      = 0;
    trace_ok = 1'b1;
    while (!valid && lat < 200) begin
      if (lat < k_d && sel !== nth_ch(m, lat / DWELL)) trace_ok = 1'b0;
      if (busy !== 1'b1) trace_ok = 1'b0;
      if (scramble) mask = 4'($urandom);
      tick;
      lat++;
    end
  endtask

  task automatic run_scan(input logic [3:0] m, input logic [3:0] in_w, input bit scramble,
                          output int lat, output bit trace_ok);
    mux_in = in_w;
    mask   = m;
    start  = 1'b1;
    tick;
    start = 1'b0;
    wait_valid(m, scramble, lat, trace_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         ok;
    logic [3:0] m, in_w, exp_d;
    int         hold_n;

    vecs[0] = '{4'b1010, 4'b1111, 4'b1010, 8};
    vecs[1] = '{4'b1111, 4'b0101, 4'b0101, 4};
    vecs[2] = '{4'b0110, 4'b1000, 4'b0000, 2};
    vecs[3] = '{4'b1111, 4'b0010, 4'b0010, 2};
    vecs[4] = '{4'b1101, 4'b1011, 4'b1001, 6};
    vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 2};

    rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0; mask = 4'd0; mux_in = 4'd0;
    tick; tick;
    check("reset_sel",   32'(sel),   32'd0);
    check("reset_data",  32'(data),  32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    rst = 1'b0;
    tick;

    // Table-driven single scans, ready held high
    ready = 1'b1;
    foreach (vecs[i]) begin
      run_scan(vecs[i].m, vecs[i].in_w, 1'b0, lat, ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_sel_trace", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      tick;
      check($sformatf("vec%0d_valid_clear", i), 32'(valid), 32'd0);
      check($sformatf("vec%0d_busy_clear", i), 32'(busy), 32'd0);
      $display("[TB] vec%0d in=%b mask=%b data=%b latency=%0d", i, vecs[i].in_w, vecs[i].m, data, lat);
    end

    // Backpressure: word held for 5 cycles, start during HOLD ignored
    ready = 1'b0;
    run_scan(4'b1111, 4'b1100, 1'b0, lat, ok);
    check("hold_latency", 32'(lat), 32'd8);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin start = 1'b1; mask = 4'b0011; mux_in = 4'b0011; end
      else start = 1'b0;
      if (data !== 4'b1100 || valid !== 1'b1 || busy !== 1'b1) ok = 1'b0;
      tick;
    end
    start = 1'b0;
    check("hold_stable", 32'(ok), 32'd1);
    check("hold_data", 32'(data), 32'b1100);
    ready = 1'b1;
    tick;
    check("hold_valid_clear", 32'(valid), 32'd0);
    check("hold_busy_clear", 32'(busy), 32'd0);
    tick;
    check("hold_start_ignored", 32'(busy), 32'd0);
    $display("[TB] hold sequence data=1100 released");

    // Continuous mode: back-to-back words
    ready = 1'b0; cont = 1'b1;
    run_scan(4'b1111, 4'b1001, 1'b0, lat, ok);
    check("cont1_latency", 32'(lat), 32'd8);
    check("cont1_data", 32'(data), 32'b1001);
    mux_in = 4'b0110; mask = 4'b1111; ready = 1'b1;
    tick;
    ready = 1'b0;
    check("cont_sel_restart", 32'(sel), 32'd0);
    check("cont_busy", 32'(busy), 32'd1);
    check("cont_valid_clear", 32'(valid), 32'd0);
    wait_valid(4'b1111, 1'b0, lat, ok);
    check("cont2_latency", 32'(lat), 32'd8);
    check("cont2_trace", 32'(ok), 32'd1);
    check("cont2_data", 32'(data), 32'b0110);
    cont = 1'b0; ready = 1'b1;
    tick;
    check("cont_end_idle", 32'(busy), 32'd0);
    ready = 1'b0;
    $display("[TB] continuous words 1001 then 0110");

    // Reset mid-scan
    mux_in = 4'b0101; mask = 4'b1111; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    #2 rst = 1'b1;
    #1;
    check("midrst_sel",   32'(sel),   32'd0);
    check("midrst_data",  32'(data),  32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy",  32'(busy),  32'd0);
    #1 rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_valid", 32'(ok), 32'd1);
    ready = 1'b1;
    run_scan(4'b1111, 4'b1010, 1'b0, lat, ok);
    check("postrst_data", 32'(data), 32'b1010);
    check("postrst_latency", 32'(lat), 32'd8);
    tick;
    $display("[TB] reset mid-scan then data=%b", data);

    // Empty mask start is ignored
    mask = 4'b0000; start = 1'b1;
    tick;
    start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (busy !== 1'b0 || sel !== 2'd0 || valid !== 1'b0) ok = 1'b0;
      tick;
    end
    check("mask0_ignored", 32'(ok), 32'd1);
    $display("[TB] mask=0000 start ignored");

    // Randomized scans; mask input scrambled mid-scan must not matter
    for (int t = 0; t < 24; t++) begin
      m      = 4'($urandom_range(1, 15));
      in_w   = 4'($urandom);
      exp_d  = in_w & m;
      hold_n = int'($urandom_range(0, 3));
      ready  = 1'b0;
      run_scan(m, in_w, 1'b1, lat, ok);
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(popcount(m) * DWELL));
      check($sformatf("rnd%0d_trace", t), 32'(ok), 32'd1);
      check($sformatf("rnd%0d_data", t), 32'(data), 32'(exp_d));
      for (int c = 0; c < hold_n; c++) begin
        tick;
        check($sformatf("rnd%0d_hold", t), 32'({valid, data}), 32'({1'b1, exp_d}));
      end
      ready = 1'b1;
      tick;
      check($sformatf("rnd%0d_release", t), 32'({valid, busy}), 32'd0);
      $display("[TB] rnd%0d in=%b mask=%b data=%b latency=%0d", t, in_w, m, exp_d, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL provide parameter DWELL, default 2, giving the clock cycles each channel is selected before its sample is taken; legal range 1..16.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request one scan; sampled only in IDLE.
REQ-005 SHALL provide port cont  input  1  continuous mode; sampled at word acceptance.
REQ-006 SHALL provide port mask  input  4  channel enable, bit n = channel n; latched at scan start.
REQ-007 SHALL provide port y_in  input  1  serial data from the upstream 4:1 mux output y.
REQ-008 SHALL provide port sel  output  2  channel select driven to the 4:1 mux sel input; registered.
REQ-009 SHALL provide port data  output  4  assembled scan word, bit n = sample of channel n.
REQ-010 SHALL provide port valid  output  1  data holds a complete word.
REQ-011 SHALL provide port ready  input  1  downstream accepts data when valid && ready.
REQ-012 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, SETTLE, HOLD; all outputs SHALL be registered.
REQ-014 In IDLE with start=1 and mask!=0, SHALL latch mask, clear the shadow word, set sel to the lowest enabled channel, clear the dwell counter, and enter SETTLE.
REQ-015 In IDLE with start=1 and mask==0, SHALL ignore the request and remain in IDLE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 In SETTLE the dwell counter SHALL increment each cycle; on the cycle the count equals DWELL-1, y_in SHALL be written to shadow bit sel.
REQ-018 After that sample, if a higher enabled channel exists in the latched mask, sel SHALL advance to the next enabled channel and the counter SHALL clear; otherwise SHALL load data from the shadow word including the current sample, set valid=1, and enter HOLD.
REQ-019 Bits of data for disabled channels SHALL be 0.
REQ-020 Latency: with k enabled channels, valid SHALL rise exactly k*DWELL cycles after the edge that accepted start.
REQ-021 In HOLD, data and valid SHALL stay stable until valid && ready.
REQ-022 On acceptance with cont=0, SHALL clear valid and enter IDLE.
REQ-023 On acceptance with cont=1 and the current mask!=0, SHALL start a new scan on the next cycle with no idle bubble, re-latch mask, and set sel to the lowest enabled channel.
REQ-024 On acceptance with cont=1 and mask==0, SHALL clear valid and enter IDLE.
REQ-025 Changes to mask during a scan SHALL not affect that scan.
REQ-026 In IDLE, sel SHALL hold 2'b00.

Reset
REQ-027 While rst=1, regardless of clk, SHALL force state=IDLE, sel=00, data=0000, valid=0, busy=0, and clear the shadow word and dwell counter.
REQ-028 Reset asserted mid-scan or in HOLD SHALL discard the partial or pending word; after release the block SHALL wait for a new start.

Verification
REQ-029 Bench SHALL cover: DWELL=2, mux in=1010, mask=1111, start pulse, ready=1 -> sel steps 0,1,2,3 every 2 cycles; valid rises 8 cycles after start; data=1010.
REQ-030 Bench SHALL cover: mux in=1111, mask=0101 -> sel visits only 0 and 2; valid after 4 cycles; data=0101.
REQ-031 Bench SHALL cover: in=1100, mask=1111, ready=0 for 5 cycles after valid -> data=1100 and valid=1 held stable; a start pulse during HOLD is ignored; ready=1 -> valid=0 next cycle; busy=0.
REQ-032 Bench SHALL cover: cont=1, in=1001 then in=0110 between scans -> back-to-back words 1001 then 0110, with sel=0 on the cycle after each acceptance.
REQ-033 Bench SHALL cover: rst pulsed mid-scan after 3 cycles -> outputs reset immediately, no valid appears; a new start with in=1010 -> data=1010.
REQ-034 Bench SHALL cover: start with mask=0000 -> busy stays 0, sel stays 00, valid stays 0.
